// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like port between inst and data masters, routes in-order responses by a queued owner ID
module sram_like_arbiter #(
  parameter int OUT_DEPTH  = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addrok,
  output logic        inst_sram_dataok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addrok,
  output logic        data_sram_dataok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addrok,
  input  logic        mem_dataok,
  input  logic [31:0] mem_rdata,
  output logic        proto_err
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);
  logic                 lock_q, lock_d, lock_id_q, lock_id_d;
  logic [OUT_DEPTH-1:0] fifo_q, fifo_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 proto_err_q, proto_err_d;
  logic                 full, gnt_id, accept, pop, head;
  logic                 unused_inst;
  assign unused_inst     = ^{inst_sram_wr, inst_sram_wstrb};
  assign inst_sram_rdata = mem_rdata;
  assign data_sram_rdata = mem_rdata;
  assign proto_err       = proto_err_q;
  always_comb begin
    full   = count_q == CW'(OUT_DEPTH);
    // gnt_id: 1 = data. Unlocked, gnt_id=0 with data_req=1 only happens when inst is
    // being rescued from starvation, so the granted req below is always the right one.
    gnt_id = lock_q ? lock_id_q : data_sram_req && !(inst_sram_req && starve_q == SW'(STARVE_LIM));
    mem_req   = !reset && (lock_q || !full) && (gnt_id ? data_sram_req : inst_sram_req);
    mem_wr    = gnt_id && data_sram_wr;
    mem_size  = gnt_id ? data_sram_size : inst_sram_size;
    mem_addr  = gnt_id ? data_sram_addr : inst_sram_addr;
    mem_wstrb = gnt_id ? data_sram_wstrb : 4'h0;
    mem_wdata = gnt_id ? data_sram_wdata : inst_sram_wdata;
    accept           = mem_req && mem_addrok;
    inst_sram_addrok = accept && !gnt_id;
    data_sram_addrok = accept && gnt_id;
    head             = fifo_q[rd_ptr_q];
    pop              = !reset && mem_dataok && count_q != '0;
    inst_sram_dataok = pop && !head;
    data_sram_dataok = pop && head;
    lock_d    = mem_req && !mem_addrok;
    lock_id_d = gnt_id;
    fifo_d    = fifo_q;
    if (accept) fifo_d[wr_ptr_q] = gnt_id;
    wr_ptr_d    = wr_ptr_q + PW'(accept);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    count_d     = count_q + CW'(accept) - CW'(pop);
    starve_d    = (!inst_sram_req || (accept && !gnt_id)) ? '0 :
                  (accept && starve_q != SW'(STARVE_LIM)) ? starve_q + SW'(1) : starve_q;
    proto_err_d = proto_err_q || (mem_dataok && count_q == '0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q      <= 1'b0;
      lock_id_q   <= 1'b0;
      fifo_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      fifo_q      <= fifo_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      proto_err_q <= proto_err_d;
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: randomized scoreboard bench for sram_like_arbiter against a transaction-level model
module tb_sram_like_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic inst_req, inst_wr, data_req, data_wr;
  logic [1:0] inst_size, data_size, mem_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0] inst_wstrb, data_wstrb, mem_wstrb;
  logic inst_addrok, inst_dataok, data_addrok, data_dataok;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
  logic mem_req, mem_wr, mem_addrok, mem_dataok, proto_err;
  int checks = 0, errors = 0;
  bit exp_q[$];
  bit pend_v, pend_id, acc_pend, acc_id, i_acc, d_acc;
  int starve;
  always #5 clk = ~clk;
  sram_like_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_req), .inst_sram_wr(inst_wr), .inst_sram_size(inst_size),
    .inst_sram_addr(inst_addr), .inst_sram_wstrb(inst_wstrb), .inst_sram_wdata(inst_wdata),
    .inst_sram_addrok(inst_addrok), .inst_sram_dataok(inst_dataok), .inst_sram_rdata(inst_rdata),
    .data_sram_req(data_req), .data_sram_wr(data_wr), .data_sram_size(data_size),
    .data_sram_addr(data_addr), .data_sram_wstrb(data_wstrb), .data_sram_wdata(data_wdata),
    .data_sram_addrok(data_addrok), .data_sram_dataok(data_dataok), .data_sram_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addrok(mem_addrok),
    .mem_dataok(mem_dataok), .mem_rdata(mem_rdata), .proto_err(proto_err)
  );
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  // Transaction model: the owner of an unaccepted request keeps the port; otherwise
  // data wins unless inst has already waited through 8 data grants, and nothing is
  // granted while 4 transactions are in flight.
  task automatic model_step();
    bit g, r, acc;
    if (pend_v) begin g = pend_id; r = g ? data_req : inst_req; end
    else if (exp_q.size() == 4) begin g = 0; r = 0; end
    else if (data_req && !(inst_req && starve == 8)) begin g = 1; r = 1; end
    else begin g = 0; r = inst_req; end
    chk("mem_req", mem_req, r);
    if (r) begin
      chk("mem_addr", mem_addr, g ? data_addr : inst_addr);
      chk("mem_size", mem_size, g ? data_size : inst_size);
      chk("mem_wdata", mem_wdata, g ? data_wdata : inst_wdata);
      chk("mem_wr", mem_wr, g ? data_wr : 1'b0);
      chk("mem_wstrb", mem_wstrb, g ? data_wstrb : 4'h0);
    end
    acc = r && mem_addrok;
    chk("inst_addrok", inst_addrok, acc && !g);
    chk("data_addrok", data_addrok, acc && g);
    if (acc) begin acc_pend = 1; acc_id = g; end
    i_acc = acc && !g;
    d_acc = acc && g;
    pend_v = r && !mem_addrok;
    pend_id = g;
    if (!inst_req) starve = 0;
    else if (acc) starve = g ? (starve < 8 ? starve + 1 : 8) : 0;
  endtask
  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (acc_pend) begin exp_q.push_back(acc_id); acc_pend = 0; end
  endtask
  task automatic idle_inputs();
    inst_req = 0; data_req = 0; mem_addrok = 0; mem_dataok = 0;
  endtask
  task automatic new_inst(int pct);
    inst_req = $urandom_range(99) < pct;
    inst_wr = 1'($urandom); inst_size = 2'($urandom); inst_addr = $urandom;
    inst_wstrb = 4'($urandom); inst_wdata = $urandom;
  endtask
  task automatic new_data(int pct);
    data_req = $urandom_range(99) < pct;
    data_wr = 1'($urandom); data_size = 2'($urandom); data_addr = $urandom;
    data_wstrb = 4'($urandom); data_wdata = $urandom;
  endtask
  task automatic rand_phase(int n, int rq, int ak, int dk);
    repeat (n) begin
      if (!inst_req || i_acc) new_inst(rq);
      if (!data_req || d_acc) new_data(rq);
      mem_addrok = $urandom_range(99) < ak;
      mem_dataok = exp_q.size() > 0 && $urandom_range(99) < dk;
      mem_rdata = $urandom;
      tick();
    end
  endtask
  task automatic drain();
    inst_req = 0; data_req = 0; mem_addrok = 0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      mem_dataok = 1; mem_rdata = $urandom; tick();
    end
    mem_dataok = 0;
    chk("drain_empty", exp_q.size(), 0);
  endtask
  // Response monitor: every dataok must go to the owner at the head of the queue.
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (mem_dataok && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("inst_dataok", inst_dataok, !e);
          chk("data_dataok", data_dataok, e);
          chk("rdata", e ? data_rdata : inst_rdata, mem_rdata);
        end else begin
          chk("inst_dataok_idle", inst_dataok, 0);
          chk("data_dataok_idle", data_dataok, 0);
        end
      end
    end
  end
  initial begin
    reset = 1;
    new_inst(100); new_data(100); mem_addrok = 1; mem_dataok = 1; mem_rdata = 0;
    pend_v = 0; starve = 0; acc_pend = 0; i_acc = 0; d_acc = 0;
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_addrok", inst_addrok, 0);
    chk("rst_data_addrok", data_addrok, 0);
    chk("rst_inst_dataok", inst_dataok, 0);
    chk("rst_data_dataok", data_dataok, 0);
    chk("rst_proto_err", proto_err, 0);
    idle_inputs();
    @(posedge clk); #1;
    reset = 0;
    // inst-only fetch, response two cycles later
    new_inst(100); inst_addr = 32'hbfc00000; inst_wr = 1; inst_wstrb = 4'hf; mem_addrok = 1;
    tick();
    inst_req = 0; mem_addrok = 0;
    tick();
    mem_dataok = 1; mem_rdata = 32'h24080001;
    tick();
    mem_dataok = 0;
    // both request together: data first, then inst
    new_inst(100); new_data(100); mem_addrok = 1;
    tick();
    data_req = 0;
    tick();
    inst_req = 0; mem_addrok = 0;
    drain();
    // inst holds the port while addrok is low even after data_req rises
    new_inst(100); mem_addrok = 0;
    tick();
    new_data(100);
    tick(); tick();
    mem_addrok = 1;
    tick();
    inst_req = 0;
    tick();
    drain();
    // response with nothing outstanding
    mem_dataok = 1; mem_rdata = 32'h12345678;
    tick();
    mem_dataok = 0;
    tick();
    chk("proto_err_set", proto_err, 1);
    // full queue, starvation, then mixed traffic
    rand_phase(12, 100, 100, 0);
    rand_phase(40, 100, 100, 100);
    rand_phase(300, 60, 60, 40);
    rand_phase(200, 90, 80, 15);
    // asynchronous reset in the middle of traffic
    rand_phase(10, 100, 100, 0);
    inst_req = 1; data_req = 1; mem_addrok = 1;
    #2;
    reset = 1;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_proto_err", proto_err, 0);
    chk("arst_count", 32'(dut.count_q), 0);
    chk("arst_inst_addrok", inst_addrok, 0);
    chk("arst_data_addrok", data_addrok, 0);
    idle_inputs();
    exp_q.delete(); pend_v = 0; starve = 0; acc_pend = 0; i_acc = 0; d_acc = 0;
    @(posedge clk); #1;
    reset = 0;
    rand_phase(200, 70, 70, 50);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
